// File: rtl/bist_tpg_lfsr.sv
// LFSR test pattern generator for the BIST path: emits NUM_PATTERNS Fibonacci-LFSR vectors per
// start/done framed run, restarting from a loadable seed so every run is reproducible.
module bist_tpg_lfsr #(
    parameter int unsigned      WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
    parameter logic [WIDTH-1:0] SEED         = 4'b0001,
    parameter int unsigned      NUM_PATTERNS = 8,
    parameter int unsigned      CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             seedLoad,
    input  logic [WIDTH-1:0] seedIn,
    input  logic             hold,
    output logic [WIDTH-1:0] patternOut,
    output logic             patternValid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] NumPat  = CNT_W'(NUM_PATTERNS);

    state_e           state_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_safe;

    always_comb begin
        lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        // An all-zero seed would lock the LFSR at zero forever.
        seed_safe = (seedIn == '0) ? WIDTH'(1) : seedIn;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            seed_q  <= SEED;
            lfsr_q  <= SEED;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (seedLoad) begin
                        seed_q <= seed_safe;
                        lfsr_q <= seed_safe;
                    end else if (start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        lfsr_q  <= seed_q;
                        count_q <= '0;
                    end
                end
                StRun: begin
                    if (!hold) begin
                        if (count_q == LastIdx) begin
                            // Last vector accepted: keep it on patternOut through DONE/IDLE.
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            count_q <= NumPat;
                        end else begin
                            lfsr_q  <= lfsr_next;
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign patternOut   = lfsr_q;
    assign patternValid = (state_q == StRun) && !hold;
    assign busy         = busy_q;
    assign done         = done_q;
    assign count        = count_q;

endmodule

// File: tb/tb_bist_tpg_lfsr.sv
// Self-checking bench for bist_tpg_lfsr: directed scenarios plus randomized runs checked against
// a sequence model built from the LFSR feedback rule.
module tb_bist_tpg_lfsr;

    localparam logic [3:0] TAPS_M = 4'b1100;

    logic       clock;
    logic       reset;
    logic       start;
    logic       seedLoad;
    logic [3:0] seedIn;
    logic       hold;
    logic [3:0] patternOut;
    logic       patternValid;
    logic       busy;
    logic       done;
    logic [7:0] count;

    logic       start15;
    logic       seed_load15;
    logic [3:0] seed_in15;
    logic       hold15;
    logic [3:0] out15;
    logic       valid15;
    logic       busy15;
    logic       done15;
    logic [7:0] count15;

    int         checks;
    int         failures;
    logic [3:0] exp_seq [8];
    logic [3:0] model_seed;

    bist_tpg_lfsr dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .seedLoad    (seedLoad),
        .seedIn      (seedIn),
        .hold        (hold),
        .patternOut  (patternOut),
        .patternValid(patternValid),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    bist_tpg_lfsr #(.NUM_PATTERNS(15)) dut15 (
        .clock       (clock),
        .reset       (reset),
        .start       (start15),
        .seedLoad    (seed_load15),
        .seedIn      (seed_in15),
        .hold        (hold15),
        .patternOut  (out15),
        .patternValid(valid15),
        .busy        (busy15),
        .done        (done15),
        .count       (count15)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Next vector: shift left by one, shift in the parity of the tapped bits.
    function automatic logic [3:0] model_step(input logic [3:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && TAPS_M[i]) ones++;
        end
        return 4'(((int'(v) * 2) % 16) + (ones % 2));
    endfunction

    task automatic test_reset();
        @(negedge clock);
        #1;
        checks++;
        if ({patternValid, busy, done, patternOut, count} !== 15'({3'b000, 4'h1, 8'd0})) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {patternValid, busy, done, patternOut, count},
                     15'({3'b000, 4'h1, 8'd0}));
        end
        checks++;
        if ({valid15, busy15, done15, out15, count15} !== 15'({3'b000, 4'h1, 8'd0})) begin
            failures++;
            $display("FAIL reset_state15 got=%h", {valid15, busy15, done15, out15, count15});
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_sequence(input string tag, input logic [3:0] load_val);
        @(negedge clock);
        seedLoad = 1'b1;
        seedIn   = load_val;
        start    = 1'b1;
        @(negedge clock);
        seedLoad = 1'b0;
        start    = 1'b0;
        #1;
        checks++;
        if ({patternValid, busy, patternOut} !== {1'b0, 1'b0, 4'h1}) begin
            failures++;
            $display("FAIL %s seed_load got=%h exp=%h", tag, {patternValid, busy, patternOut},
                     {1'b0, 1'b0, 4'h1});
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b110, exp_seq[k], 8'(k)}) begin
                failures++;
                $display("FAIL %s vec k=%0d got=%h exp=%h", tag, k,
                         {patternValid, busy, done, patternOut, count}, {3'b110, exp_seq[k], 8'(k)});
            end
        end
        @(negedge clock);
        #1;
        checks++;
        if ({patternValid, busy, done, patternOut, count} !== {3'b001, 4'ha, 8'd8}) begin
            failures++;
            $display("FAIL %s done got=%h exp=%h", tag, {patternValid, busy, done, patternOut, count},
                     {3'b001, 4'ha, 8'd8});
        end
        @(negedge clock);
        #1;
        checks++;
        if ({patternValid, busy, done, patternOut, count} !== {3'b000, 4'ha, 8'd8}) begin
            failures++;
            $display("FAIL %s after_done got=%h exp=%h", tag,
                     {patternValid, busy, done, patternOut, count}, {3'b000, 4'ha, 8'd8});
        end
    endtask

    task automatic test_hold();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b110, exp_seq[k], 8'(k)}) begin
                failures++;
                $display("FAIL hold_pre k=%0d got=%h", k, {patternValid, busy, done, patternOut, count});
            end
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clock);
            hold = 1'b1;
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b010, 4'h4, 8'd2}) begin
                failures++;
                $display("FAIL hold_frozen h=%0d got=%h exp=%h", h,
                         {patternValid, busy, done, patternOut, count}, {3'b010, 4'h4, 8'd2});
            end
        end
        @(negedge clock);
        hold = 1'b0;
        for (int k = 2; k < 8; k++) begin
            if (k > 2) @(negedge clock);
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b110, exp_seq[k], 8'(k)}) begin
                failures++;
                $display("FAIL hold_post k=%0d got=%h", k, {patternValid, busy, done, patternOut, count});
            end
        end
        @(negedge clock);
        #1;
        checks++;
        if ({busy, done, count} !== {2'b01, 8'd8}) begin
            failures++;
            $display("FAIL hold_done got=%h exp=%h", {busy, done, count}, {2'b01, 8'd8});
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k < 3; k++) @(negedge clock);
        #1;
        checks++;
        if (patternOut !== 4'h4) begin
            failures++;
            $display("FAIL midrun_pre got=%h exp=4", patternOut);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({patternValid, busy, done, patternOut, count} !== {3'b000, 4'h1, 8'd0}) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=%h", {patternValid, busy, done, patternOut, count},
                     {3'b000, 4'h1, 8'd0});
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b000, 4'h1, 8'd0}) begin
                failures++;
                $display("FAIL midrun_idle c=%0d got=%h", c, {patternValid, busy, done, patternOut, count});
            end
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b110, exp_seq[k], 8'(k)}) begin
                failures++;
                $display("FAIL midrun_rerun k=%0d got=%h", k, {patternValid, busy, done, patternOut, count});
            end
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_ignore_in_run();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            seedLoad = (k == 3);
            seedIn   = 4'hf;
            start    = (k == 5);
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b110, exp_seq[k], 8'(k)}) begin
                failures++;
                $display("FAIL ignore_run k=%0d got=%h", k, {patternValid, busy, done, patternOut, count});
            end
        end
        @(negedge clock);
        seedLoad = 1'b0;
        start    = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        checks++;
        if ({patternValid, busy, done, patternOut, count} !== {3'b110, 4'h1, 8'd0}) begin
            failures++;
            $display("FAIL ignore_restart got=%h", {patternValid, busy, done, patternOut, count});
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic test_random(input int runs);
        logic [3:0] vec [8];
        logic [3:0] s;
        int         k;
        int         guard;
        for (int r = 0; r < runs; r++) begin
            @(negedge clock);
            hold = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                s          = 4'($urandom_range(0, 15));
                seedLoad   = 1'b1;
                seedIn     = s;
                model_seed = (s == 4'h0) ? 4'h1 : s;
                @(negedge clock);
                seedLoad = 1'b0;
            end
            start  = 1'b1;
            vec[0] = model_seed;
            for (int i = 1; i < 8; i++) vec[i] = model_step(vec[i-1]);
            @(negedge clock);
            k     = 0;
            guard = 0;
            while (k < 8 && guard < 64) begin
                start    = 1'($urandom_range(0, 1));
                seedLoad = 1'($urandom_range(0, 1));
                seedIn   = 4'($urandom);
                hold     = ($urandom_range(0, 2) == 0);
                #1;
                checks++;
                if ({patternValid, busy, done, patternOut, count} !== {!hold, 2'b10, vec[k], 8'(k)}) begin
                    failures++;
                    $display("FAIL rand r=%0d k=%0d got=%h exp=%h", r, k,
                             {patternValid, busy, done, patternOut, count},
                             {!hold, 2'b10, vec[k], 8'(k)});
                end
                if (!hold) k++;
                guard++;
                @(negedge clock);
            end
            checks++;
            if (k < 8) begin
                failures++;
                $display("FAIL rand_timeout r=%0d got=%0d exp=8", r, k);
            end
            start    = 1'($urandom_range(0, 1));
            seedLoad = 1'b0;
            hold     = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b001, vec[7], 8'd8}) begin
                failures++;
                $display("FAIL rand_done r=%0d got=%h exp=%h", r,
                         {patternValid, busy, done, patternOut, count}, {3'b001, vec[7], 8'd8});
            end
            @(negedge clock);
            start = 1'b0;
            hold  = 1'b0;
            #1;
            checks++;
            if ({patternValid, busy, done, patternOut, count} !== {3'b000, vec[7], 8'd8}) begin
                failures++;
                $display("FAIL rand_idle r=%0d got=%h exp=%h", r,
                         {patternValid, busy, done, patternOut, count}, {3'b000, vec[7], 8'd8});
            end
        end
    endtask

    task automatic test_long_run();
        logic       seen [16];
        logic [3:0] cur;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        cur = 4'h1;
        @(negedge clock);
        start15 = 1'b1;
        @(negedge clock);
        start15 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            checks++;
            if ({valid15, busy15, done15, out15, count15} !== {3'b110, cur, 8'(k)}) begin
                failures++;
                $display("FAIL long k=%0d got=%h exp=%h", k, {valid15, busy15, done15, out15, count15},
                         {3'b110, cur, 8'(k)});
            end
            checks++;
            if (out15 == 4'h0 || seen[out15]) begin
                failures++;
                $display("FAIL long_distinct k=%0d got=%h", k, out15);
            end
            seen[out15] = 1'b1;
            if (k < 14) cur = model_step(cur);
        end
        @(negedge clock);
        #1;
        checks++;
        if ({valid15, busy15, done15, out15, count15} !== {3'b001, cur, 8'd15}) begin
            failures++;
            $display("FAIL long_done got=%h exp=%h", {valid15, busy15, done15, out15, count15},
                     {3'b001, cur, 8'd15});
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        start       = 1'b0;
        seedLoad    = 1'b0;
        seedIn      = 4'h0;
        hold        = 1'b0;
        start15     = 1'b0;
        seed_load15 = 1'b0;
        seed_in15   = 4'h0;
        hold15      = 1'b0;
        model_seed  = 4'h1;
        exp_seq     = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hd, 4'ha};

        test_reset();
        test_sequence("basic", 4'h1);
        test_sequence("lockup_guard", 4'h0);
        test_hold();
        test_reset_midrun();
        test_ignore_in_run();
        test_long_run();
        test_random(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bist_tpg_lfsr.md
Name: bist_tpg_lfsr

Overview:
LFSR-based test pattern generator (TPG) for the BIST path. It drives pseudo-random vectors into the circuit under test, whose responses are compacted by the MISR output response analyzer. A start/done handshake frames a run of NUM_PATTERNS vectors, and a seed register makes each run reproducible so the MISR golden signature is stable.

Parameters:
WIDTH, 4, pattern/LFSR width in bits
TAPS, 4'b1100, feedback tap mask; bit i set = state[i] XORed into feedback (default x^4+x^3+1, primitive)
SEED, 4'b0001, seed register value after reset; must be nonzero
NUM_PATTERNS, 8, vectors emitted per run; legal range 1..2^CNT_W-1
CNT_W, 8, width of the pattern counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin a run; sampled in IDLE only
seedLoad  input  1  capture seedIn into the seed register; sampled in IDLE only
seedIn  input  WIDTH  new seed value
hold  input  1  pause generation during RUN
patternOut  output  WIDTH  current test vector (LFSR state)
patternValid  output  1  patternOut is a live vector this cycle
busy  output  1  high in RUN
done  output  1  one-cycle pulse at end of run
count  output  CNT_W  vectors issued in the current or last run

Behaviour:
- Reset (reset=0, async): state=IDLE; seedReg=SEED; lfsr=SEED; count=0; patternOut=SEED; patternValid=0; busy=0; done=0. Takes effect immediately, including mid-run. No resumption after reset: a fresh start is required.
- LFSR step (Fibonacci): fb = XOR-reduce(lfsr & TAPS); next = {lfsr[WIDTH-2:0], fb}. patternOut = lfsr at all times.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If seedLoad=1: seedReg <= seedIn, or 1 if seedIn==0 (lockup guard); lfsr <= same value. start is ignored in that cycle because seedLoad has priority.
  - Else if start=1: go to RUN; lfsr <= seedReg; count <= 0.
  - busy=0, patternValid=0.
- RUN:
  - busy=1.
  - patternValid = (state==RUN) & ~hold. This is combinational on hold.
  - On each edge with hold=0: if count==NUM_PATTERNS-1, go to DONE; count <= NUM_PATTERNS; lfsr is not advanced. Otherwise lfsr <= next and count <= count+1.
  - With hold=1: lfsr and count are frozen, and the same vector is re-presented when hold drops.
  - start and seedLoad are ignored.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, patternValid=0. Then returns to IDLE.
  - A start seen in DONE is ignored; it must be reasserted in IDLE.
- Latency: start is sampled at edge N, and the first vector (= seedReg) is valid during cycle N+1. Vector k (k = 0..NUM_PATTERNS-1) is valid after the k-th non-held RUN edge. done is high during the cycle after the edge that accepted the last vector.
- count, lfsr and patternOut hold their end-of-run values through DONE and IDLE until the next seedLoad or start. count == NUM_PATTERNS after a completed run.
- NUM_PATTERNS=1: one vector is issued, then DONE.
- A run longer than 2^WIDTH-1 vectors wraps the LFSR sequence. This is legal, and the repeated vectors are issued unchanged.

Test Plan:
- Reset; seedLoad with seedIn=0001; start; hold=0; defaults -> patternOut with patternValid=1 on 8 consecutive cycles: 0001,0010,0100,1001,0011,0110,1101,1010. Then done=1 for exactly one cycle, count=8, busy=0.
- seedLoad with seedIn=0000, then start -> first vector 0001 (lockup guard); sequence identical to the previous scenario.
- Run from seed 0001 with hold=1 for 3 cycles while vector 0100 is valid -> patternValid=0 for those 3 cycles. patternOut stays 0100, count stays 2. After release: 0100, then 1001 ... 1010. done arrives 3 cycles later than in the unheld run.
- Mid-run (after 0100), assert reset=0 for 1 cycle -> immediate IDLE, patternOut=0001, count=0, busy=0, no done pulse. A new start reproduces the full 8-vector sequence.
- During RUN, pulse seedLoad with seedIn=1111 and pulse start -> both ignored; the sequence is unchanged. The next IDLE start still begins from 0001.
- NUM_PATTERNS=15 -> 15 distinct nonzero vectors. The 16th run from the last state would repeat 0001. done follows the 15th vector, and count=15.
